// File: rtl/proc_pkg.sv
// proc_pkg: shared datapath widths, register indices and flag bit positions.
package proc_pkg;
  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] R0 = 3'd0;
  localparam logic [ADDR_W-1:0] R1 = 3'd1;
  localparam logic [ADDR_W-1:0] R2 = 3'd2;
  localparam logic [ADDR_W-1:0] R3 = 3'd3;
  localparam logic [ADDR_W-1:0] R4 = 3'd4;
  localparam logic [ADDR_W-1:0] R5 = 3'd5;
  localparam logic [ADDR_W-1:0] R6 = 3'd6;
  localparam logic [ADDR_W-1:0] R7 = 3'd7;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: register select mux with same-cycle write-through bypass.
module regfile_read_port #(
  parameter int WIDTH = proc_pkg::WIDTH,
  parameter int NREGS = proc_pkg::NREGS,
  parameter int ADDR_W = proc_pkg::ADDR_W
) (
  input  logic [NREGS-1:0][WIDTH-1:0] regs,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data
);
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) if (rd_addr == ADDR_W'(i)) rd_data = regs[i];
    if (wr_en && wr_addr == rd_addr && wr_addr != '0) rd_data = wr_data;
  end
endmodule

// File: rtl/alu_writeback_regfile.sv
// alu_writeback_regfile: 2R1W register file with R0 hardwired to zero, Z/N flags and write-back ack.
module alu_writeback_regfile
  import proc_pkg::*;
#(
  parameter int WIDTH = proc_pkg::WIDTH,
  parameter int NREGS = proc_pkg::NREGS,
  parameter int ADDR_W = proc_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              flag_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              flag_z,
  output logic              flag_n,
  output logic              wb_ack
);
  logic [NREGS-1:0][WIDTH-1:0] r_regs;
  logic [1:0]                  r_flags;
  logic                        r_wb_ack;
  // R0 storage is never written, so it stays at its reset value of zero
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_regs   <= '0;
      r_flags  <= '0;
      r_wb_ack <= 1'b0;
    end else begin
      if (wr_en && wr_addr != '0) r_regs[wr_addr] <= wr_data;
      if (wr_en && flag_en) begin
        r_flags[FLAG_Z] <= (wr_data == '0);
        r_flags[FLAG_N] <= wr_data[WIDTH-1];
      end
      r_wb_ack <= wr_en;
    end
  regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_rd_a (
    .regs(r_regs), .rd_addr(rd_addr_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data_a)
  );
  regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_rd_b (
    .regs(r_regs), .rd_addr(rd_addr_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_data(rd_data_b)
  );
  assign flag_z = r_flags[FLAG_Z];
  assign flag_n = r_flags[FLAG_N];
  assign wb_ack = r_wb_ack;
endmodule

// File: tb/tb_alu_writeback_regfile.sv
// tb_alu_writeback_regfile: directed and randomized checks against an array-based reference model.
module tb_alu_writeback_regfile;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        flag_en = 1'b0;
  logic [2:0]  rd_addr_a = '0;
  logic [2:0]  rd_addr_b = '0;
  logic [15:0] rd_data_a, rd_data_b;
  logic        flag_z, flag_n, wb_ack;
  int errors = 0;
  int checks = 0;
  logic [15:0] m_reg [8];
  logic m_z = 1'b0, m_n = 1'b0, m_ack = 1'b0;

  alu_writeback_regfile dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flag_en(flag_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .flag_z(flag_z), .flag_n(flag_n), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  task automatic tick;
    @(posedge clk);
    if (!rst_n) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_z = 1'b0;
      m_n = 1'b0;
      m_ack = 1'b0;
    end else begin
      if (wr_en && wr_addr != 3'd0) m_reg[wr_addr] = wr_data;
      if (wr_en && flag_en) begin
        m_z = (wr_data == 16'h0);
        m_n = wr_data[15];
      end
      m_ack = wr_en;
    end
    #1;
  endtask

  task automatic test_reset;
    foreach (m_reg[i]) m_reg[i] = 16'hDEAD;
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hFFFF; flag_en = 1'b1;
    tick(); tick();
    wr_en = 1'b0; flag_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i); #1;
      checks++;
      if (rd_data_a !== 16'h0) begin errors++; $display("FAIL reset_read r%0d got=%h exp=0000", i, rd_data_a); end
    end
    checks++;
    if ({flag_z, flag_n, wb_ack} !== 3'b000) begin errors++; $display("FAIL reset_status got=%b exp=000", {flag_z, flag_n, wb_ack}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_readback;
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234; flag_en = 1'b1;
    tick();
    wr_en = 1'b0; flag_en = 1'b0; rd_addr_a = 3'd5; #1;
    checks++;
    if (rd_data_a !== 16'h1234) begin errors++; $display("FAIL readback_r5 got=%h exp=1234", rd_data_a); end
    checks++;
    if ({flag_z, flag_n, wb_ack} !== 3'b001) begin errors++; $display("FAIL readback_status got=%b exp=001", {flag_z, flag_n, wb_ack}); end
    tick();
    checks++;
    if (wb_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse got=%b exp=0", wb_ack); end
  endtask

  task automatic test_bypass;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF; flag_en = 1'b0; rd_addr_a = 3'd2; rd_addr_b = 3'd2; #1;
    checks++;
    if ({rd_data_a, rd_data_b} !== {16'hBEEF, 16'hBEEF}) begin
      errors++; $display("FAIL bypass got=%h/%h exp=beef/beef", rd_data_a, rd_data_b);
    end
    tick();
    wr_en = 1'b0; #1;
    checks++;
    if (rd_data_b !== 16'hBEEF) begin errors++; $display("FAIL bypass_stored got=%h exp=beef", rd_data_b); end
  endtask

  task automatic test_r0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h8000; flag_en = 1'b1; rd_addr_a = 3'd0; #1;
    checks++;
    if (rd_data_a !== 16'h0) begin errors++; $display("FAIL r0_bypass got=%h exp=0000", rd_data_a); end
    tick();
    wr_en = 1'b0; flag_en = 1'b0; #1;
    checks++;
    if (rd_data_a !== 16'h0) begin errors++; $display("FAIL r0_read got=%h exp=0000", rd_data_a); end
    checks++;
    if ({flag_z, flag_n, wb_ack} !== 3'b011) begin errors++; $display("FAIL r0_status got=%b exp=011", {flag_z, flag_n, wb_ack}); end
  endtask

  task automatic test_flag_hold;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0F0F; flag_en = 1'b0;
    tick();
    wr_data = 16'h0000;
    tick();
    wr_en = 1'b0; rd_addr_b = 3'd4; #1;
    checks++;
    if (rd_data_b !== 16'h0000) begin errors++; $display("FAIL hold_r4 got=%h exp=0000", rd_data_b); end
    checks++;
    if ({flag_z, flag_n} !== 2'b01) begin errors++; $display("FAIL flag_hold got=%b exp=01", {flag_z, flag_n}); end
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0000; flag_en = 1'b1;
    tick();
    wr_en = 1'b0; flag_en = 1'b0; #1;
    checks++;
    if ({flag_z, flag_n} !== 2'b10) begin errors++; $display("FAIL flag_zero got=%b exp=10", {flag_z, flag_n}); end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'(16'h0011 * i); flag_en = 1'b1;
      tick();
      checks++;
      if (wb_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack cycle=%0d got=%b exp=1", i, wb_ack); end
    end
    wr_en = 1'b0; flag_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(i); #1;
      checks++;
      if ({rd_data_a, rd_data_b} !== {m_reg[i], m_reg[i]} || m_reg[i] !== 16'(16'h0011 * i)) begin
        errors++; $display("FAIL b2b_read r%0d got=%h/%h exp=%h", i, rd_data_a, rd_data_b, 16'(16'h0011 * i));
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i <= 4; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'(16'h0100 * i + 1); flag_en = 1'b1;
      rst_n = (i != 4);
      tick();
    end
    rst_n = 1'b1; wr_en = 1'b0; flag_en = 1'b0;
    checks++;
    if ({flag_z, flag_n, wb_ack} !== 3'b000) begin errors++; $display("FAIL midreset_status got=%b exp=000", {flag_z, flag_n, wb_ack}); end
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); #1;
      checks++;
      if (rd_data_a !== 16'h0) begin errors++; $display("FAIL midreset_read r%0d got=%h exp=0000", i, rd_data_a); end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(31) != 0);
      wr_en = $urandom_range(1);
      wr_addr = 3'($urandom_range(7));
      wr_data = ($urandom_range(7) == 0) ? 16'h0 : 16'($urandom);
      flag_en = $urandom_range(1);
      rd_addr_a = 3'($urandom_range(7));
      rd_addr_b = ($urandom_range(3) == 0) ? wr_addr : 3'($urandom_range(7));
      #1;
      checks++;
      if ({rd_data_a, rd_data_b} !== {exp_rd(rd_addr_a), exp_rd(rd_addr_b)}) begin
        errors++; $display("FAIL rand_read n=%0d a=%0d b=%0d got=%h/%h exp=%h/%h", n, rd_addr_a, rd_addr_b,
          rd_data_a, rd_data_b, exp_rd(rd_addr_a), exp_rd(rd_addr_b));
      end
      tick();
      checks++;
      if ({flag_z, flag_n, wb_ack} !== {m_z, m_n, m_ack}) begin
        errors++; $display("FAIL rand_status n=%0d got=%b exp=%b", n, {flag_z, flag_n, wb_ack}, {m_z, m_n, m_ack});
      end
    end
    rst_n = 1'b1; wr_en = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_write_readback();
    test_bypass();
    test_r0();
    test_flag_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_writeback_regfile.md
Name: alu_writeback_regfile

Overview:
- Register file that sits directly downstream of the 16-bit ALU logic and arithmetic units; it consumes the ALU result bus and stores it.
- 8 x 16-bit registers with two combinational read ports (operands A/B back to the ALU) and one synchronous write port.
- Captures Zero/Negative status flags from the written value.
- Pulses a write-back acknowledge so the unpipelined control unit can advance.

Parameters:
- WIDTH, 16, data width of registers and ALU result.
- NREGS, 8, number of architectural registers.
- ADDR_W, 3, register address width; must equal log2(NREGS).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- wr_en  input  1  write request for the current cycle.
- wr_addr  input  ADDR_W  destination register.
- wr_data  input  WIDTH  ALU result to store.
- flag_en  input  1  update Z/N flags with this write; ignored when wr_en=0.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_a  output  WIDTH  operand A to ALU.
- rd_data_b  output  WIDTH  operand B to ALU.
- flag_z  output  1  registered zero flag.
- flag_n  output  1  registered negative flag (wr_data MSB).
- wb_ack  output  1  one-cycle pulse, high the cycle after an accepted write.

Behaviour:
- Reset:
  - When rst_n=0 at a clk edge, all registers go to 0, and flag_z, flag_n and wb_ack go to 0.
  - Reset wins over a simultaneous wr_en.
  - Reset mid-sequence discards any in-flight ack.
- R0:
  - Hardwired zero; reads always return 0.
  - A write to address 0 is accepted: wb_ack pulses and flags update if flag_en=1, but storage is unchanged.
- Write:
  - On a rising edge with rst_n=1 and wr_en=1, reg[wr_addr] <= wr_data; latency is 1 cycle.
- Reads:
  - Combinational from rd_addr_x.
  - Write-through bypass: if wr_en=1, wr_addr==rd_addr_x and wr_addr!=0, then rd_data_x = wr_data in the same cycle.
  - Both ports may read the same address simultaneously.
- Flags:
  - On an accepted write with flag_en=1: flag_z <= (wr_data==0), flag_n <= wr_data[WIDTH-1].
  - Flags are computed from wr_data even for R0 writes.
  - With flag_en=0 or wr_en=0, flags hold.
- wb_ack:
  - wb_ack <= wr_en each cycle; it is not held.
  - Back-to-back writes give a continuous high, one cycle delayed.
- Out-of-range addresses: none are possible, since NREGS = 2^ADDR_W.
- No X propagation: the read mux must default to 0.

Decomposition:
- Shared package (proc_pkg):
  - WIDTH and ADDR_W constants.
  - Register index constants R0..R7.
  - Flag bit positions FLAG_Z=0, FLAG_N=1, for later reuse by the branch unit.
- One natural sub-module: regfile_read_port. It is an 8:1 WIDTH-bit mux plus bypass compare, instantiated twice for ports A and B.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with wr_en=1, wr_addr=3, wr_data=16'hFFFF. Then all reads return 0, flag_z=0, flag_n=0 and wb_ack=0, with no write having occurred.
- Write/readback: write 16'h1234 to R5 with flag_en=1. Next cycle, rd_addr_a=5 gives 16'h1234, wb_ack=1, flag_z=0, flag_n=0; the following cycle wb_ack=0.
- Bypass: wr_en=1, wr_addr=2, wr_data=16'hBEEF, rd_addr_a=rd_addr_b=2 in the same cycle. Both outputs show 16'hBEEF before the clock edge.
- R0:
  - Write 16'h8000 to R0 with flag_en=1. rd_data_a at address 0 stays 0 (bypass too), flag_n=1, flag_z=0 and wb_ack pulses.
  - Then write 0 to R1 with flag_en=1, giving flag_z=1 and flag_n=0.
- Flag hold: write 16'h0000 to R4 with flag_en=0 after the flags are Z=0, N=1. Flags stay Z=0, N=1 and R4 reads 0.
- Back-to-back and reset mid-operation:
  - Write R1..R7 on consecutive cycles with values 16'h0011*i. wb_ack stays high for 7 cycles, and all values read back.
  - Assert rst_n=0 during the 4th write. All registers clear, and wb_ack=0 the next cycle.
